div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 start_i  input  1  request to begin a division; sampled only in IDLE.
REQ-004 alu_op_i  input  5  ALU operation code: 01110 div, 01111 divu, 10000 rem, 10001 remu.
REQ-005 op_a_i  input  32  dividend; captured on the accepting edge.
REQ-006 op_b_i  input  32  divisor; captured on the accepting edge.
REQ-007 flush_i  input  1  abort the operation in flight; no result is produced.
REQ-008 busy_o  output  1  high from the accepting edge until the DONE cycle ends; pipeline stall request.
REQ-009 done_o  output  1  one-cycle pulse marking result_o valid.
REQ-010 result_o  output  32  quotient or remainder; holds its value until the next done_o.

Function
REQ-011 The FSM SHALL have four states: IDLE, CALC, FIX, DONE.
REQ-012 In IDLE, start_i=1 with alu_op_i in {01110..10001} and flush_i=0 SHALL accept the operation: capture operands and op, go to CALC, and load iteration counter=31.
REQ-013 A start_i with any other alu_op_i SHALL be ignored (state stays IDLE, busy_o stays 0).
REQ-014 Signed ops (div, rem) SHALL divide absolute values; unsigned ops use raw operands.
REQ-015 CALC SHALL perform one restoring radix-2 step per cycle (shift remainder/dividend left by 1, trial subtract, set quotient bit), decrement the counter, and go to FIX after the step with counter=0 (32 steps).
REQ-016 FIX SHALL apply sign correction: quotient negated if the operand signs differ; remainder takes the sign of the dividend. Then go to DONE.
REQ-017 DONE SHALL drive done_o=1 and result_o=quotient (div/divu) or remainder (rem/remu) for exactly one cycle, then return to IDLE.
REQ-018 Latency without early-out: done_o high in the 35th cycle after the accepting edge (32 CALC + 1 FIX + 1 DONE).
REQ-019 Divisor zero: quotient=0xFFFFFFFF for both div and divu; remainder=dividend.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF, div or rem): quotient=0x80000000, remainder=0.
REQ-021 start_i while busy_o=1 SHALL be ignored; it is not queued.
REQ-022 flush_i=1 in any state SHALL force IDLE on the next edge with no done_o; result_o is unchanged.
REQ-023 flush_i and start_i both high in IDLE: flush SHALL win and the operation is not accepted.
REQ-024 busy_o SHALL be high in CALC, FIX, and DONE, and low in IDLE.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state=IDLE, counter=0, busy_o=0, done_o=0, result_o=0x00000000, and clear all internal operand registers.
REQ-026 Reset asserted mid-operation SHALL discard the operation; no done_o follows deassertion.

Configuration
REQ-027 Macro DIV_EARLY_OUT_EN: when defined, an accepted op with divisor zero or signed overflow SHALL skip CALC/FIX and go directly to DONE. done_o is then high in the 2nd cycle after the accepting edge, and results are per REQ-019/020.
REQ-028 Without DIV_EARLY_OUT_EN, all ops SHALL take the full latency of REQ-018, and the special-case results SHALL still match REQ-019/020 exactly.

Verification
REQ-029 div 0xFFFFFFF9 (-7) / 2 -> result_o=0xFFFFFFFD (-3), done_o 35 cycles after accept, busy_o high throughout.
REQ-030 rem -7 / 2 -> 0xFFFFFFFF (-1); remu 0xFFFFFFF9 / 2 -> 0x00000001; divu 100 / 7 -> 0x0000000E.
REQ-031 divu 5 / 0 -> 0xFFFFFFFF; rem 5 / 0 -> 0x00000005; with DIV_EARLY_OUT_EN, done_o 2 cycles after accept.
REQ-032 div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem of the same operands -> 0x00000000.
REQ-033 flush_i asserted at CALC cycle 10 -> IDLE next edge, no done_o, result_o holds its prior value; a new start then completes normally.
REQ-034 reset_n pulsed low mid-CALC -> all outputs 0 immediately; start_i during busy and start_i with alu_op_i=00000 -> both ignored.

Source files
------------

// File: rtl/div_ctrl.sv
// Iterative 32-bit restoring divider for div/divu/rem/remu.
// Define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow without iterating.
module div_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [4:0]  alu_op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic        is_rem;
  logic        a_neg;
  logic        q_neg;
  logic        dz;

  logic        valid_op;
  logic        sgn_in;
  logic        zero_in;
  logic        early;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] shl;
  logic [32:0] diff;
  logic        ge;

  assign valid_op = (alu_op_i == 5'b01110) || (alu_op_i == 5'b01111)
                 || (alu_op_i == 5'b10000) || (alu_op_i == 5'b10001);
  assign sgn_in   = ~alu_op_i[0];
  assign zero_in  = (op_b_i == 32'd0);
  assign a_abs    = (sgn_in && op_a_i[31]) ? -op_a_i : op_a_i;
  assign b_abs    = (sgn_in && op_b_i[31]) ? -op_b_i : op_b_i;

`ifdef DIV_EARLY_OUT_EN
  logic ovf_in;
  assign ovf_in = sgn_in && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
  assign early  = zero_in || ovf_in;
`else
  assign early  = 1'b0;
`endif

  // quo doubles as the dividend shift register; quotient bits enter at the bottom
  assign shl  = {rem, quo[31]};
  assign diff = shl - {1'b0, dsr};
  assign ge   = ~diff[32];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 5'd0;
      quo      <= 32'd0;
      rem      <= 32'd0;
      dsr      <= 32'd0;
      is_rem   <= 1'b0;
      a_neg    <= 1'b0;
      q_neg    <= 1'b0;
      dz       <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= 32'd0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start_i && valid_op) begin
              busy_o <= 1'b1;
              is_rem <= alu_op_i[4];
              a_neg  <= sgn_in & op_a_i[31];
              q_neg  <= sgn_in & (op_a_i[31] ^ op_b_i[31]);
              dz     <= zero_in;
              dsr    <= b_abs;
              cnt    <= 5'd31;
              if (early) begin
                quo   <= zero_in ? 32'hFFFF_FFFF : 32'h8000_0000;
                rem   <= zero_in ? op_a_i : 32'd0;
                state <= DONE;
              end else begin
                quo   <= a_abs;
                rem   <= 32'd0;
                state <= CALC;
              end
            end
          end
          CALC: begin
            rem <= ge ? diff[31:0] : shl[31:0];
            quo <= {quo[30:0], ge};
            cnt <= cnt - 5'd1;
            if (cnt == 5'd0) state <= FIX;
          end
          FIX: begin
            // divide-by-zero quotient is all ones regardless of sign
            if (dz) quo <= 32'hFFFF_FFFF;
            else if (q_neg) quo <= -quo;
            if (a_neg) rem <= -rem;
            state <= DONE;
          end
          DONE: begin
            done_o   <= 1'b1;
            result_o <= is_rem ? rem : quo;
            busy_o   <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized self-checking bench for div_ctrl.
// Reference results come from plain SV signed/unsigned arithmetic.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  alu_op_i = 5'd0;
  logic [31:0] op_a_i = 32'd0;
  logic [31:0] op_b_i = 32'd0;
  logic        flush_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res = 32'd0;

  localparam logic [4:0] OP_DIV  = 5'b01110;
  localparam logic [4:0] OP_DIVU = 5'b01111;
  localparam logic [4:0] OP_REM  = 5'b10000;
  localparam logic [4:0] OP_REMU = 5'b10001;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .alu_op_i (alu_op_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [4:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    bit special;
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
    return special ? 1 : 34;
`else
    return special ? 34 : 34;
`endif
  endfunction

  // poke: raise start_i with other operands mid-operation; it must be ignored
  task automatic run_op(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int n;
    bit busy_ok;
    logic [31:0] exp;
    exp = ref_res(op, a, b);
    @(negedge clk);
    start_i = 1'b1; alu_op_i = op; op_a_i = a; op_b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!done_o && n < 60) begin
      if (!busy_o) busy_ok = 1'b0;
      if (poke && n == 3) begin
        start_i = 1'b1; alu_op_i = OP_DIVU; op_a_i = 32'd9; op_b_i = 32'd3;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start_i = 1'b0;
    chk({tag, "_lat"}, n, ref_lat(op, a, b));
    chk({tag, "_res"}, result_o, exp);
    chk({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
    last_res = exp;
  endtask

  task automatic no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
    chk(tag, seen, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      4: return -$urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] ops [4];
    ops[0] = OP_DIV; ops[1] = OP_DIVU; ops[2] = OP_REM; ops[3] = OP_REMU;

    #12;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_res", result_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("remu_f9_2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1'b0);
    run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 1'b0);
    run_op("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("busy_start", OP_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1);

    // flush at CALC cycle 10
    @(negedge clk);
    start_i = 1'b1; alu_op_i = OP_DIVU; op_a_i = 32'd77; op_b_i = 32'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_busy", {31'd0, busy_o}, 32'd0);
    chk("flush_res", result_o, last_res);
    no_done("flush_nodone", 40);
    run_op("after_flush", OP_REMU, 32'd77, 32'd5, 1'b0);

    // reset mid-CALC
    @(negedge clk);
    start_i = 1'b1; alu_op_i = OP_DIV; op_a_i = 32'd500; op_b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_done", {31'd0, done_o}, 32'd0);
    chk("mid_rst_res", result_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    no_done("rst_nodone", 40);

    // illegal op and flush+start in IDLE
    @(negedge clk);
    start_i = 1'b1; alu_op_i = 5'b00000; op_a_i = 32'd9; op_b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("bad_op_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; alu_op_i = OP_DIV;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", {31'd0, busy_o}, 32'd0);
    no_done("idle_nodone", 40);

    for (int i = 0; i < 30; i++)
      run_op($sformatf("rnd%0d", i), ops[$urandom_range(0, 3)], pick(), pick(), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
